ahb_slave_bridge: RTL and testbench
===================================

AHB_SLAVE_BRIDGE -- requirements
Module: ahb_slave_bridge

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, default 32, address width.
- DATA_W, default 32, data width; legal values 32 or 64.
- BASE_ADDR, default 0, first decoded byte address.
- MEM_BYTES, default 262144, decoded window size; power of two.
- MEM_LAT, default 1, memory read latency in cycles; range 0..7.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- HSel  in  1  slave select.
- HGrant  in  1  bus granted to current master.
- HTrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWrite  in  1  1 = write.
- HSize  in  3  000 byte, 001 half, 010 word, 011 dword (DATA_W=64 only).
- HAddress  in  ADDR_W  byte address, address phase.
- HWrite_data  in  DATA_W  write data, data phase.
- HRead_data  out  DATA_W  read data.
- HReady  out  1  transfer done / accept next address.
- HResp  out  2  00 OKAY, 01 ERROR.
- MAddress  out  ADDR_W  word address offset from BASE_ADDR.
- MWrite_data  out  DATA_W  memory write data.
- Mbyte_en  out  DATA_W/8  byte lane enables.
- Mwrite  out  1  memory write strobe.
- Menable  out  1  memory access strobe.
- MRead_data  in  DATA_W  memory read data.

Function
REQ-003 An address phase SHALL be accepted on a rising edge where HReady=1, HSel=1, HGrant=1 and HTrans[1]=1; IDLE/BUSY SHALL be ignored with OKAY, zero wait.
REQ-004 FSM states SHALL be IDLE, WRITE, READ, ERR1 and ERR2. An accepted transfer SHALL enter WRITE, READ or ERR1.
REQ-005 WRITE SHALL last one cycle: Menable=1, Mwrite=1, MWrite_data=HWrite_data, HReady=1, HResp=OKAY.
REQ-006 READ SHALL assert Menable=1, Mwrite=0 in its first cycle only.
REQ-007 READ SHALL hold HReady=0 for MEM_LAT cycles via a 3-bit down-counter, then drive HReady=1 with HRead_data=MRead_data; MEM_LAT=0 gives zero wait.
REQ-008 MAddress and Mbyte_en SHALL be registered at address acceptance and held stable through the data phase.
REQ-009 MAddress SHALL be (HAddress-BASE_ADDR) truncated to log2(MEM_BYTES) bits and aligned to DATA_W/8.
REQ-010 Mbyte_en SHALL cover 2^HSize contiguous lanes starting at HAddress[log2(DATA_W/8)-1:0].
REQ-011 A new address phase SHALL be accepted in the same cycle that the prior data phase completes with HReady=1 (pipelined, no bubble).
REQ-012 ERR1 SHALL drive HReady=0, HResp=ERROR; ERR2 SHALL drive HReady=1, HResp=ERROR; neither SHALL assert Menable. Any address sampled during ERR2 SHALL be dropped.
REQ-013 When no transfer is active, outputs SHALL be HReady=1, HResp=OKAY, Menable=0, Mwrite=0.

Reset
REQ-014 rst low SHALL asynchronously force IDLE and counter=0, and drive: HReady=1, HResp=OKAY, HRead_data=0, MAddress=0, MWrite_data=0, Mbyte_en=0, Mwrite=0, Menable=0.
REQ-015 Reset asserted mid-read or mid-error SHALL abandon the transfer with no further memory strobe after release.

Configuration
REQ-016 Macro SLAVE_ERR_RESP_EN:
- Defined: an address outside [BASE_ADDR, BASE_ADDR+MEM_BYTES), a misaligned HSize, or dword at DATA_W=32 SHALL take ERR1/ERR2.
- Undefined: ERR states SHALL be absent; the address SHALL wrap modulo MEM_BYTES, misaligned lanes SHALL be truncated, and HResp SHALL be constant OKAY.

Structure
REQ-017 Package ahb_pkg SHALL hold the htrans_t, hresp_t, hsize_t and bridge_state_t enums and the response constants.
REQ-018 Sub-module ahb_slave_decode SHALL be combinational and compute range/alignment error, offset address and Mbyte_en.

Verification
REQ-019 Write 0x0000_0010, HSize=010, data 0xDEADBEEF -> one cycle later Menable=1, Mwrite=1, MAddress=0x10, Mbyte_en=4'hF, HReady=1.
REQ-020 MEM_LAT=3, read 0x20, memory returns 0xCAFEF00D -> HReady low exactly 3 cycles, then HRead_data=0xCAFEF00D with OKAY.
REQ-021 Back-to-back write 0x4 then read 0x8 (MEM_LAT=1) -> read address accepted in the write data-phase cycle, one read wait cycle, no idle gap.
REQ-022 Macro defined, read 0x0004_0000 with MEM_BYTES=0x40000 -> HResp=ERROR for 2 cycles, HReady 0 then 1, Menable stays 0. Macro undefined, same stimulus -> MAddress=0x0 with OKAY.
REQ-023 Byte write at 0x3 -> Mbyte_en=4'b1000. Half write at 0x1 -> ERROR when the macro is defined.
REQ-024 rst low during a MEM_LAT=5 read wait -> outputs take reset values immediately; after release no Menable until a new transfer.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared types and response constants for the AHB slave-to-memory bridge.
// The error states exist only when SLAVE_ERR_RESP_EN is defined.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [1:0] {
      RESP_OKAY  = 2'b00,
      RESP_ERROR = 2'b01
   } hresp_t;

   typedef enum logic [2:0] {
      SIZE_BYTE  = 3'b000,
      SIZE_HALF  = 3'b001,
      SIZE_WORD  = 3'b010,
      SIZE_DWORD = 3'b011
   } hsize_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ
`ifdef SLAVE_ERR_RESP_EN
      ,
      ST_ERR1,
      ST_ERR2
`endif
   } bridge_state_t;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

endpackage

// File: rtl/ahb_slave_bridge_if.sv
// AHB slave-side bus plus the simple memory port driven by the bridge.
interface ahb_slave_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                HSel;
   logic                HGrant;
   logic [1:0]          HTrans;
   logic                HWrite;
   logic [2:0]          HSize;
   logic [ADDR_W-1:0]   HAddress;
   logic [DATA_W-1:0]   HWrite_data;
   logic [DATA_W-1:0]   HRead_data;
   logic                HReady;
   logic [1:0]          HResp;
   logic [ADDR_W-1:0]   MAddress;
   logic [DATA_W-1:0]   MWrite_data;
   logic [DATA_W/8-1:0] Mbyte_en;
   logic                Mwrite;
   logic                Menable;
   logic [DATA_W-1:0]   MRead_data;

   modport slave (
      input  HSel, HGrant, HTrans, HWrite, HSize, HAddress, HWrite_data, MRead_data,
      output HRead_data, HReady, HResp, MAddress, MWrite_data, Mbyte_en, Mwrite, Menable
   );

   modport master (
      output HSel, HGrant, HTrans, HWrite, HSize, HAddress, HWrite_data, MRead_data,
      input  HRead_data, HReady, HResp, MAddress, MWrite_data, Mbyte_en, Mwrite, Menable
   );
endinterface

// File: rtl/ahb_slave_decode.sv
// Combinational address decode: window offset, lane enables and, with
// SLAVE_ERR_RESP_EN, the range/alignment error flag.
module ahb_slave_decode
   import ahb_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int                MEM_BYTES = 262144
) (
   input  logic [ADDR_W-1:0]   addr,
   input  logic [2:0]          size,
   output logic [ADDR_W-1:0]   maddr,
   output logic [DATA_W/8-1:0] ben
`ifdef SLAVE_ERR_RESP_EN
   ,
   output logic                err
`endif
);
   localparam int NB = DATA_W / 8;
   localparam int LB = $clog2(NB);
   localparam logic [ADDR_W-1:0] MASK = ADDR_W'(MEM_BYTES - 1) & ~ADDR_W'(NB - 1);

   logic [ADDR_W-1:0] offset;
   logic [LB-1:0]     lo;
   logic [NB-1:0]     span;

   assign offset = addr - BASE_ADDR;
   assign lo     = addr[LB-1:0];
   // Masking the offset both wraps modulo the window and aligns to the bus width.
   assign maddr  = offset & MASK;

   always_comb begin
      span = '1;
      case (hsize_t'(size))
         SIZE_BYTE:  span = NB'(1);
         SIZE_HALF:  span = NB'(3);
         SIZE_WORD:  span = NB'(15);
         SIZE_DWORD: span = NB'(255);
         default:    span = '1;
      endcase
   end

   assign ben = span << lo;

`ifdef SLAVE_ERR_RESP_EN
   localparam logic [ADDR_W:0] LO_LIM = {1'b0, BASE_ADDR};
   localparam logic [ADDR_W:0] HI_LIM = LO_LIM + (ADDR_W+1)'(MEM_BYTES);

   logic [LB-1:0] amask;
   logic          range_err;
   logic          align_err;
   logic          size_err;

   assign amask     = LB'((9'd1 << size) - 9'd1);
   assign range_err = ({1'b0, addr} < LO_LIM) || ({1'b0, addr} >= HI_LIM);
   assign align_err = (lo & amask) != '0;
   assign size_err  = int'(size) > LB;
   assign err       = range_err || align_err || size_err;
`endif

endmodule

// File: rtl/ahb_slave_bridge.sv
// AHB slave to simple synchronous memory bridge with pipelined address phases.
// Optional error responses are enabled by defining SLAVE_ERR_RESP_EN.
//
// state    | meaning
// ST_IDLE  | no data phase in progress, HReady=1
// ST_WRITE | one-cycle write data phase, memory strobed
// ST_READ  | read data phase, waits MEM_LAT cycles
// ST_ERR1  | first error cycle, HReady=0
// ST_ERR2  | second error cycle, HReady=1, sampled address dropped
module ahb_slave_bridge
   import ahb_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int                MEM_BYTES = 262144,
   parameter int                MEM_LAT   = 1
) (
   input logic               clk,
   input logic               rst,
   ahb_slave_bridge_if.slave bus
);
   localparam int         NB  = DATA_W / 8;
   localparam logic [2:0] LAT = 3'(MEM_LAT);

   bridge_state_t     state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] maddr_q, maddr_d;
   logic [NB-1:0]     ben_q, ben_d;

   logic [ADDR_W-1:0] dec_addr;
   logic [NB-1:0]     dec_ben;
   logic              accept;
   logic              hready;
   logic [1:0]        hresp;
   logic              menable;
   logic              mwrite;
   logic [DATA_W-1:0] mwdata;
   logic [DATA_W-1:0] rdata;
   htrans_t           trans;

`ifdef SLAVE_ERR_RESP_EN
   logic dec_err;
`endif

   assign trans = htrans_t'(bus.HTrans);

   ahb_slave_decode #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .BASE_ADDR (BASE_ADDR),
      .MEM_BYTES (MEM_BYTES)
   ) u_decode (
      .addr  (bus.HAddress),
      .size  (bus.HSize),
      .maddr (dec_addr),
      .ben   (dec_ben)
`ifdef SLAVE_ERR_RESP_EN
      ,
      .err   (dec_err)
`endif
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         maddr_q <= '0;
         ben_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         maddr_q <= maddr_d;
         ben_q   <= ben_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      maddr_d = maddr_q;
      ben_d   = ben_q;
      hready  = 1'b1;
      hresp   = HRESP_OKAY;
      menable = 1'b0;
      mwrite  = 1'b0;
      mwdata  = '0;
      rdata   = '0;

      case (state_q)
         ST_WRITE: begin
            menable = 1'b1;
            mwrite  = 1'b1;
            mwdata  = bus.HWrite_data;
         end
         ST_READ: begin
            // Counter still at its load value only in the first read cycle.
            menable = (cnt_q == LAT);
            if (cnt_q != 3'd0) begin
               hready = 1'b0;
               cnt_d  = cnt_q - 3'd1;
            end else begin
               rdata = bus.MRead_data;
            end
         end
`ifdef SLAVE_ERR_RESP_EN
         ST_ERR1: begin
            hready  = 1'b0;
            hresp   = HRESP_ERROR;
            state_d = ST_ERR2;
         end
         ST_ERR2: begin
            hresp = HRESP_ERROR;
         end
`endif
         default: ;
      endcase

      accept = hready && bus.HSel && bus.HGrant &&
               ((trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ));
`ifdef SLAVE_ERR_RESP_EN
      if (state_q == ST_ERR2) accept = 1'b0;
`endif

      if (hready) begin
         state_d = ST_IDLE;
         if (accept) begin
            maddr_d = dec_addr;
            ben_d   = dec_ben;
            cnt_d   = LAT;
            state_d = bus.HWrite ? ST_WRITE : ST_READ;
`ifdef SLAVE_ERR_RESP_EN
            if (dec_err) state_d = ST_ERR1;
`endif
         end
      end
   end

   assign bus.HReady      = hready;
   assign bus.HResp       = hresp;
   assign bus.HRead_data  = rdata;
   assign bus.MAddress    = maddr_q;
   assign bus.Mbyte_en    = ben_q;
   assign bus.MWrite_data = mwdata;
   assign bus.Mwrite      = mwrite;
   assign bus.Menable     = menable;

endmodule

// File: tb/tb_ahb_slave_bridge.sv
// Directed bench for ahb_slave_bridge: three instances at MEM_LAT 1, 3 and 5
// share one stimulus bus; each scenario checks the instance it targets.
module tb_ahb_slave_bridge;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        hsel = 1'b0;
   logic        hgrant = 1'b0;
   logic [1:0]  htrans = 2'b00;
   logic        hwrite = 1'b0;
   logic [2:0]  hsize = 3'b000;
   logic [31:0] haddr = '0;
   logic [31:0] hwdata = '0;
   logic [31:0] mrdata = '0;

   logic [2:0]  hready_v, mwrite_v, menable_v;
   logic [1:0]  hresp_v  [3];
   logic [31:0] rdata_v  [3];
   logic [31:0] maddr_v  [3];
   logic [31:0] mwdata_v [3];
   logic [3:0]  ben_v    [3];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      ahb_slave_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

      assign bus.HSel        = hsel;
      assign bus.HGrant      = hgrant;
      assign bus.HTrans      = htrans;
      assign bus.HWrite      = hwrite;
      assign bus.HSize       = hsize;
      assign bus.HAddress    = haddr;
      assign bus.HWrite_data = hwdata;
      assign bus.MRead_data  = mrdata;

      assign hready_v[g]  = bus.HReady;
      assign mwrite_v[g]  = bus.Mwrite;
      assign menable_v[g] = bus.Menable;
      assign hresp_v[g]   = bus.HResp;
      assign rdata_v[g]   = bus.HRead_data;
      assign maddr_v[g]   = bus.MAddress;
      assign mwdata_v[g]  = bus.MWrite_data;
      assign ben_v[g]     = bus.Mbyte_en;

      ahb_slave_bridge #(
         .ADDR_W    (32),
         .DATA_W    (32),
         .BASE_ADDR (32'h0),
         .MEM_BYTES (262144),
         .MEM_LAT   ((g == 0) ? 1 : (g == 1) ? 3 : 5)
      ) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic addr_phase(input logic wr, input logic [2:0] sz, input logic [31:0] a);
      htrans = 2'b10;
      hwrite = wr;
      hsize  = sz;
      haddr  = a;
   endtask

   task automatic bus_idle();
      htrans = 2'b00;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int low;
      int men;
      bit done;

      // reset values
      @(negedge clk);
      @(negedge clk);
      check("rst_hready",  hready_v[0], 1);
      check("rst_hresp",   hresp_v[0], 0);
      check("rst_rdata",   rdata_v[0], 0);
      check("rst_maddr",   maddr_v[0], 0);
      check("rst_mwdata",  mwdata_v[0], 0);
      check("rst_ben",     ben_v[0], 0);
      check("rst_mwrite",  mwrite_v[0], 0);
      check("rst_menable", menable_v[0], 0);
      tick();
      rst = 1'b1;
      hsel = 1'b1;
      hgrant = 1'b1;
      tick();

      // single word write
      addr_phase(1'b1, 3'b010, 32'h10);
      tick();
      bus_idle();
      hwdata = 32'hDEADBEEF;
      @(negedge clk);
      check("wr_menable", menable_v[0], 1);
      check("wr_mwrite",  mwrite_v[0], 1);
      check("wr_maddr",   maddr_v[0], 32'h10);
      check("wr_ben",     ben_v[0], 4'hF);
      check("wr_hready",  hready_v[0], 1);
      check("wr_mwdata",  mwdata_v[0], 32'hDEADBEEF);
      tick();
      @(negedge clk);
      check("wr_after_menable", menable_v[0], 0);
      check("wr_after_hready",  hready_v[0], 1);
      tick();

      // MEM_LAT=3 read on instance 1
      mrdata = 32'hCAFEF00D;
      addr_phase(1'b0, 3'b010, 32'h20);
      tick();
      bus_idle();
      low = 0;
      men = 0;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (menable_v[1]) men++;
         if (hready_v[1]) done = 1'b1;
         else begin
            low++;
            tick();
         end
      end
      check("lat3_done",    done, 1);
      check("lat3_waits",   low, 3);
      check("lat3_menable", men, 1);
      check("lat3_rdata",   rdata_v[1], 32'hCAFEF00D);
      check("lat3_hresp",   hresp_v[1], 0);
      check("lat3_maddr",   maddr_v[1], 32'h20);
      tick();
      tick();

      // back-to-back write then read, MEM_LAT=1
      mrdata = 32'h55AA55AA;
      addr_phase(1'b1, 3'b010, 32'h4);
      tick();
      hwdata = 32'h11223344;
      addr_phase(1'b0, 3'b010, 32'h8);
      @(negedge clk);
      check("b2b_wr_menable", menable_v[0], 1);
      check("b2b_wr_mwrite",  mwrite_v[0], 1);
      check("b2b_wr_maddr",   maddr_v[0], 32'h4);
      check("b2b_wr_hready",  hready_v[0], 1);
      tick();
      bus_idle();
      @(negedge clk);
      check("b2b_rd_menable", menable_v[0], 1);
      check("b2b_rd_mwrite",  mwrite_v[0], 0);
      check("b2b_rd_maddr",   maddr_v[0], 32'h8);
      check("b2b_rd_wait",    hready_v[0], 0);
      tick();
      @(negedge clk);
      check("b2b_rd_hready",  hready_v[0], 1);
      check("b2b_rd_rdata",   rdata_v[0], 32'h55AA55AA);
      check("b2b_rd_men_off", menable_v[0], 0);
      tick();
      @(negedge clk);
      check("b2b_idle_hready", hready_v[0], 1);
      check("b2b_idle_rdata",  rdata_v[0], 0);

      // read just past the window
      addr_phase(1'b0, 3'b010, 32'h0004_0000);
      tick();
      bus_idle();
`ifdef SLAVE_ERR_RESP_EN
      @(negedge clk);
      check("oor_err1_hresp",   hresp_v[0], 1);
      check("oor_err1_hready",  hready_v[0], 0);
      check("oor_err1_menable", menable_v[0], 0);
      tick();
      addr_phase(1'b1, 3'b010, 32'h0);
      @(negedge clk);
      check("oor_err2_hresp",   hresp_v[0], 1);
      check("oor_err2_hready",  hready_v[0], 1);
      check("oor_err2_menable", menable_v[0], 0);
      tick();
      bus_idle();
      @(negedge clk);
      check("oor_drop_menable", menable_v[0], 0);
      check("oor_drop_hresp",   hresp_v[0], 0);
      tick();
`else
      @(negedge clk);
      check("wrap_maddr",   maddr_v[0], 32'h0);
      check("wrap_hresp",   hresp_v[0], 0);
      check("wrap_menable", menable_v[0], 1);
      check("wrap_wait",    hready_v[0], 0);
      tick();
      @(negedge clk);
      check("wrap_hready",  hready_v[0], 1);
      tick();
`endif

      // byte write at 0x3
      addr_phase(1'b1, 3'b000, 32'h3);
      tick();
      bus_idle();
      @(negedge clk);
      check("byte_ben",     ben_v[0], 4'b1000);
      check("byte_maddr",   maddr_v[0], 32'h0);
      check("byte_menable", menable_v[0], 1);
      tick();

      // aligned half write at 0x2
      addr_phase(1'b1, 3'b001, 32'h2);
      tick();
      bus_idle();
      @(negedge clk);
      check("half2_ben",   ben_v[0], 4'b1100);
      check("half2_hresp", hresp_v[0], 0);
      tick();

      // misaligned half write at 0x1
      addr_phase(1'b1, 3'b001, 32'h1);
      tick();
      bus_idle();
      @(negedge clk);
`ifdef SLAVE_ERR_RESP_EN
      check("half1_hresp",   hresp_v[0], 1);
      check("half1_hready",  hready_v[0], 0);
      check("half1_menable", menable_v[0], 0);
      tick();
      @(negedge clk);
      check("half1_err2_hresp",  hresp_v[0], 1);
      check("half1_err2_hready", hready_v[0], 1);
      tick();
`else
      check("half1_ben",     ben_v[0], 4'b0110);
      check("half1_hresp",   hresp_v[0], 0);
      check("half1_menable", menable_v[0], 1);
      tick();
`endif

      // reset during a MEM_LAT=5 read wait on instance 2
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      addr_phase(1'b0, 3'b010, 32'h20);
      tick();
      bus_idle();
      @(negedge clk);
      check("lat5_first_menable", menable_v[2], 1);
      check("lat5_first_wait",    hready_v[2], 0);
      check("lat5_first_maddr",   maddr_v[2], 32'h20);
      tick();
      #1;
      rst = 1'b0;
      #1;
      check("mid_rst_hready",  hready_v[2], 1);
      check("mid_rst_hresp",   hresp_v[2], 0);
      check("mid_rst_maddr",   maddr_v[2], 0);
      check("mid_rst_ben",     ben_v[2], 0);
      check("mid_rst_menable", menable_v[2], 0);
      check("mid_rst_rdata",   rdata_v[2], 0);
      tick();
      rst = 1'b1;
      men = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (menable_v[2]) men++;
      end
      check("post_rst_menable", men, 0);
      check("post_rst_hready",  hready_v[2], 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
